key_event: RTL and testbench

Wishbone-mapped key event detector that consumes the debounced, active-low key level produced by `debounce` (`o_key_n`). It detects press and release edges, counts presses, flags long presses against a programmable threshold, and raises a level interrupt. It sits directly downstream of `debounce` on the same Wishbone bus and clock.

---
 rtl/key_event.sv | 134 +++++++++++++
 tb/tb_key_event.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_event.sv
// Key event detector on the debounced active-low key: press/release edges, press count,
// long-press detection against a tick threshold, and a registered level interrupt.
module key_event #(
   parameter int ASIZE    = 2,
   parameter int DSIZE    = 8,
   parameter int TICK_DIV = 10000
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [ASIZE-1:0] i_wb_adr,
   input  logic             i_wb_stb,
   input  logic             i_wb_we,
   input  logic [DSIZE-1:0] i_wb_dat,
   input  logic             i_key_n,
   output logic             o_wb_ack,
   output logic [DSIZE-1:0] o_wb_dat,
   output logic             o_irq
);

   localparam int PW = $clog2(TICK_DIV);

   logic [3:0]       ctrl;
   logic [7:0]       long_th;
   logic [7:0]       count;
   logic [7:0]       hold;
   logic [7:0]       hold_next;
   logic [PW-1:0]    presc;
   logic             st_press, st_rel, st_long, st_ovf;
   logic             key_q;
   logic             armed;
   logic             en;
   logic             acc, wr;
   logic             wr_ctrl, wr_th, wr_stat, wr_cnt;
   logic             press_edge, rel_edge, holding, presc_wrap, long_hit;
   logic [DSIZE-1:0] rd_data;

   // Handshake: a transfer is accepted on the edge where stb is high and ack is low;
   // ack pulses for that one cycle and the master drops stb after seeing it.
   assign acc     = i_wb_stb & ~o_wb_ack;
   assign wr      = acc & i_wb_we;
   assign wr_ctrl = wr & (i_wb_adr == ASIZE'(0));
   assign wr_th   = wr & (i_wb_adr == ASIZE'(1));
   assign wr_stat = wr & (i_wb_adr == ASIZE'(2));
   assign wr_cnt  = wr & (i_wb_adr == ASIZE'(3));

   assign en         = ctrl[0];
   assign press_edge = en & key_q & ~i_key_n;
   assign rel_edge   = en & ~key_q & i_key_n;
   // Only a press seen while enabled arms the hold timer, so a key already low at enable never times out.
   assign holding    = en & armed & ~key_q & ~i_key_n;
   assign presc_wrap = holding && (presc == PW'(TICK_DIV - 1));
   assign hold_next  = hold + 8'd1;
   assign long_hit   = presc_wrap && (hold != 8'hFF) && (long_th != 8'd0) && (hold_next == long_th);

   always_comb begin
      rd_data = '0;
      case (i_wb_adr)
         ASIZE'(0): rd_data[3:0] = ctrl;
         ASIZE'(1): rd_data[7:0] = long_th;
         ASIZE'(2): rd_data[7:0] = {3'b000, st_ovf, ~key_q, st_long, st_rel, st_press};
         default:   rd_data[7:0] = count;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wb_ack <= 1'b0;
         o_wb_dat <= '0;
      end else begin
         o_wb_ack <= i_wb_stb & ~o_wb_ack;
         if (acc & ~i_wb_we)
            o_wb_dat <= rd_data;
      end
   end

   // Flag updates: a set in the same cycle as its W1C wins.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ctrl     <= 4'h0;
         long_th  <= 8'd100;
         st_press <= 1'b0;
         st_rel   <= 1'b0;
         st_long  <= 1'b0;
         st_ovf   <= 1'b0;
         count    <= 8'd0;
         key_q    <= 1'b1;
         o_irq    <= 1'b0;
      end else begin
         key_q <= i_key_n;
         if (wr_ctrl)
            ctrl <= i_wb_dat[3:0];
         if (wr_th)
            long_th <= i_wb_dat[7:0];
         st_press <= (st_press & ~(wr_stat & i_wb_dat[0])) | press_edge;
         st_rel   <= (st_rel   & ~(wr_stat & i_wb_dat[1])) | rel_edge;
         st_long  <= (st_long  & ~(wr_stat & i_wb_dat[2])) | long_hit;
         st_ovf   <= (st_ovf   & ~(wr_stat & i_wb_dat[4])) | (press_edge & st_press);
         if (press_edge)
            count <= wr_cnt ? 8'd1 : count + 8'd1;
         else if (wr_cnt)
            count <= 8'd0;
         o_irq <= |({st_long, st_rel, st_press} & ctrl[3:1]);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         presc <= '0;
         hold  <= 8'd0;
         armed <= 1'b0;
      end else if (!en) begin
         presc <= '0;
         hold  <= 8'd0;
         armed <= 1'b0;
      end else if (press_edge) begin
         presc <= '0;
         hold  <= 8'd0;
         armed <= 1'b1;
      end else if (rel_edge) begin
         presc <= '0;
         hold  <= 8'd0;
         armed <= 1'b0;
      end else if (holding) begin
         if (presc_wrap) begin
            presc <= '0;
            if (hold != 8'hFF)
               hold <= hold_next;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with TICK_DIV=4: bus access, edge flags, long press,
// W1C/overflow, count wrap, disable and mid-press reset.
module tb_key_event;

   localparam int TICK_DIV = 4;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic [1:0] i_wb_adr;
   logic       i_wb_stb;
   logic       i_wb_we;
   logic [7:0] i_wb_dat;
   logic       i_key_n;
   logic       o_wb_ack;
   logic [7:0] o_wb_dat;
   logic       o_irq;

   int         vectors     = 0;
   int         miscompares = 0;
   logic [7:0] exp_q[$];

   key_event #(.ASIZE(2), .DSIZE(8), .TICK_DIV(TICK_DIV)) dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_wb_adr (i_wb_adr),
      .i_wb_stb (i_wb_stb),
      .i_wb_we  (i_wb_we),
      .i_wb_dat (i_wb_dat),
      .i_key_n  (i_key_n),
      .o_wb_ack (o_wb_ack),
      .o_wb_dat (o_wb_dat),
      .o_irq    (o_irq)
   );

   // clock / reset
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200000ns");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   // driver tasks
   task automatic wb_write(input logic [1:0] adr, input logic [7:0] dat, input bit press_now = 1'b0);
      @(negedge i_clk);
      i_wb_stb = 1'b1;
      i_wb_we  = 1'b1;
      i_wb_adr = adr;
      i_wb_dat = dat;
      if (press_now)
         i_key_n = 1'b0;
      @(negedge i_clk);
      check("wr_ack", o_wb_ack, 8'd1);
      i_wb_stb = 1'b0;
      i_wb_we  = 1'b0;
      @(negedge i_clk);
      check("wr_ack_single", o_wb_ack, 8'd0);
   endtask

   task automatic wb_read(input logic [1:0] adr, input logic [7:0] exp, input string tag);
      logic [7:0] rd;
      exp_q.push_back(exp);
      @(negedge i_clk);
      i_wb_stb = 1'b1;
      i_wb_we  = 1'b0;
      i_wb_adr = adr;
      @(negedge i_clk);
      check("rd_ack", o_wb_ack, 8'd1);
      rd = o_wb_dat;
      i_wb_stb = 1'b0;
      @(negedge i_clk);
      check("rd_ack_single", o_wb_ack, 8'd0);
      check({tag, "_hold"}, o_wb_dat, exp);
      check(tag, rd, exp_q.pop_front());
   endtask

   task automatic press(input int low, input int high);
      i_key_n = 1'b0;
      tick(low);
      i_key_n = 1'b1;
      tick(high);
   endtask

   initial begin
      i_rst_n  = 1'b0;
      i_wb_adr = 2'd0;
      i_wb_stb = 1'b0;
      i_wb_we  = 1'b0;
      i_wb_dat = 8'h00;
      i_key_n  = 1'b1;
      tick(2);
      check("rst_ack", o_wb_ack, 8'd0);
      check("rst_dat", o_wb_dat, 8'h00);
      check("rst_irq", o_irq, 8'd0);
      i_rst_n = 1'b1;

      // register reset values and readback
      wb_read(2'd0, 8'h00, "rst_ctrl");
      wb_read(2'd1, 8'd100, "rst_long_th");
      wb_read(2'd2, 8'h00, "rst_status");
      wb_read(2'd3, 8'd0, "rst_count");
      wb_write(2'd0, 8'h0F);
      wb_write(2'd1, 8'd3);
      wb_read(2'd0, 8'h0F, "ctrl_rb");
      wb_read(2'd1, 8'd3, "long_th_rb");

      // short press: PRESS at the first low edge, irq one edge later
      wb_write(2'd0, 8'h03);
      i_key_n = 1'b0;
      @(negedge i_clk);
      check("short_irq_edge0", o_irq, 8'd0);
      @(negedge i_clk);
      check("short_irq_edge1", o_irq, 8'd1);
      tick(4);
      i_key_n = 1'b1;
      tick(2);
      wb_read(2'd2, 8'h03, "short_status");
      wb_read(2'd3, 8'd1, "short_count");

      // W1C clears flags, irq falls
      wb_write(2'd2, 8'h17);
      check("w1c_irq_low", o_irq, 8'd0);
      wb_read(2'd2, 8'h00, "w1c_status");

      // long press: LONG exactly 12 cycles after the press edge, irq at 13
      wb_write(2'd0, 8'h09);
      i_key_n = 1'b0;
      for (int k = 0; k <= 13; k++) begin
         @(negedge i_clk);
         check($sformatf("long_irq_k%0d", k), o_irq, (k == 13) ? 8'd1 : 8'd0);
      end
      wb_read(2'd2, 8'h0D, "long_status_held");
      wb_write(2'd2, 8'h04);
      check("long_clr_irq", o_irq, 8'd0);
      wb_read(2'd2, 8'h09, "long_once");
      i_key_n = 1'b1;
      tick(16);
      check("long_after_rel_irq", o_irq, 8'd0);
      wb_read(2'd2, 8'h03, "long_status_rel");
      wb_read(2'd3, 8'd2, "long_count");

      // overflow and W1C
      wb_write(2'd2, 8'h17);
      wb_write(2'd3, 8'h00);
      wb_write(2'd0, 8'h03);
      press(3, 3);
      press(3, 3);
      check("ovf_irq", o_irq, 8'd1);
      wb_read(2'd2, 8'h13, "ovf_status");
      wb_read(2'd3, 8'd2, "ovf_count");
      wb_write(2'd2, 8'h17);
      check("ovf_clr_irq", o_irq, 8'd0);
      wb_read(2'd2, 8'h00, "ovf_clr_status");
      wb_write(2'd2, 8'h01, 1'b1);
      wb_read(2'd2, 8'h09, "w1c_vs_press");
      i_key_n = 1'b1;
      tick(2);
      wb_read(2'd2, 8'h03, "w1c_vs_press_rel");

      // 256 presses wrap COUNT; COUNT write with a press gives 1
      wb_write(2'd2, 8'h17);
      wb_write(2'd0, 8'h01);
      wb_write(2'd3, 8'h00);
      for (int n = 0; n < 256; n++)
         press(2, 2);
      wb_read(2'd3, 8'd0, "wrap_count");
      wb_read(2'd2, 8'h13, "wrap_status");
      wb_write(2'd3, 8'hAA, 1'b1);
      wb_read(2'd3, 8'd1, "cnt_wr_vs_press");
      i_key_n = 1'b1;
      tick(2);

      // EN=0 ignores edges; enabling while held reports no press
      wb_write(2'd2, 8'h17);
      wb_write(2'd0, 8'h00);
      press(2, 2);
      press(2, 2);
      wb_read(2'd3, 8'd1, "dis_count");
      wb_read(2'd2, 8'h00, "dis_status");
      i_key_n = 1'b0;
      tick(2);
      wb_write(2'd0, 8'h01);
      tick(3);
      wb_read(2'd2, 8'h08, "en_held_status");
      wb_read(2'd3, 8'd1, "en_held_count");
      i_key_n = 1'b1;
      tick(2);
      wb_read(2'd2, 8'h02, "en_held_rel");
      press(2, 2);
      wb_read(2'd3, 8'd2, "en_fresh_count");

      // reset in the middle of a long press
      wb_write(2'd2, 8'h17);
      wb_write(2'd1, 8'd3);
      wb_write(2'd0, 8'h0B);
      i_key_n = 1'b0;
      tick(6);
      check("mid_irq_before", o_irq, 8'd1);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("mid_rst_irq", o_irq, 8'd0);
      check("mid_rst_ack", o_wb_ack, 8'd0);
      check("mid_rst_dat", o_wb_dat, 8'h00);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      tick(20);
      check("post_rst_irq", o_irq, 8'd0);
      wb_read(2'd2, 8'h08, "post_rst_status");
      wb_read(2'd0, 8'h00, "post_rst_ctrl");
      wb_read(2'd1, 8'd100, "post_rst_long_th");
      wb_read(2'd3, 8'd0, "post_rst_count");
      i_key_n = 1'b1;
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
